// File: rtl/dispatch_pkg.sv
// Shared layout, sizing and lane-compression helpers for the dispatch wakeup queue.
package dispatch_pkg;

   // Default field widths of the packed entry format.
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned TAG_W_DEF  = 6;
   localparam int unsigned RD_W_DEF   = 5;
   localparam int unsigned CTRL_W_DEF = 12;

   // Upper bound on enqueue lanes handled by the lane helpers.
   localparam int unsigned MAX_LANES = 32;

   // Entry layout, LSB first: ctrl_signal, rd, s1_valid, s1_vt, s2_valid, s2_vt.
   function automatic int unsigned off_ctrl();
      return 0;
   endfunction

   function automatic int unsigned off_rd(input int unsigned ctrl_w);
      return ctrl_w;
   endfunction

   function automatic int unsigned off_s1_valid(input int unsigned ctrl_w, input int unsigned rd_w);
      return ctrl_w + rd_w;
   endfunction

   function automatic int unsigned off_s1_vt(input int unsigned ctrl_w, input int unsigned rd_w);
      return ctrl_w + rd_w + 1;
   endfunction

   function automatic int unsigned off_s2_valid(input int unsigned ctrl_w, input int unsigned rd_w,
                                                input int unsigned data_w);
      return ctrl_w + rd_w + 1 + data_w;
   endfunction

   function automatic int unsigned off_s2_vt(input int unsigned ctrl_w, input int unsigned rd_w,
                                             input int unsigned data_w);
      return ctrl_w + rd_w + 2 + data_w;
   endfunction

   // Field offsets for the default configuration.
   localparam int unsigned OFF_CTRL     = off_ctrl();
   localparam int unsigned OFF_RD       = off_rd(CTRL_W_DEF);
   localparam int unsigned OFF_S1_VALID = off_s1_valid(CTRL_W_DEF, RD_W_DEF);
   localparam int unsigned OFF_S1_VT    = off_s1_vt(CTRL_W_DEF, RD_W_DEF);
   localparam int unsigned OFF_S2_VALID = off_s2_valid(CTRL_W_DEF, RD_W_DEF, DATA_W_DEF);
   localparam int unsigned OFF_S2_VT    = off_s2_vt(CTRL_W_DEF, RD_W_DEF, DATA_W_DEF);

   // Number of set bits among the low n bits of v.
   function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v, input int unsigned n);
      int unsigned c;
      c = 0;
      for (int unsigned i = 0; i < n; i++) begin
         if (v[i]) c++;
      end
      return c;
   endfunction

   // Slot offset from tail for a lane: valid lanes below it, so gaps compress away.
   function automatic int unsigned slot_offset(input logic [MAX_LANES-1:0] v, input int unsigned lane);
      return popcount(v, lane);
   endfunction

endpackage

// File: rtl/operand_wakeup.sv
// Wakes one waiting operand from the CDB broadcast ports; lowest matching port wins.
module operand_wakeup #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TAG_W     = 6,
   parameter int unsigned CDB_PORTS = 2
) (
   input  logic                          valid_i,
   input  logic [DATA_W-1:0]             vt_i,
   input  logic [CDB_PORTS-1:0]          cdb_valid_i,
   input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag_i,
   input  logic [CDB_PORTS*DATA_W-1:0]   cdb_value_i,
   output logic                          valid_o,
   output logic [DATA_W-1:0]             vt_o
);

   logic hit;

   // Tag match against the low TAG_W bits of a not-yet-valid operand.
   always_comb begin
      hit     = 1'b0;
      valid_o = valid_i;
      vt_o    = vt_i;
      for (int unsigned p = 0; p < CDB_PORTS; p++) begin
         if (!valid_i && !hit && cdb_valid_i[p] &&
             (cdb_tag_i[p*TAG_W +: TAG_W] == vt_i[TAG_W-1:0])) begin
            hit     = 1'b1;
            valid_o = 1'b1;
            vt_o    = cdb_value_i[p*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/dispatch_wakeup_queue.sv
// In-order dispatch queue: multi-lane enqueue, CDB operand wakeup, single head release.
module dispatch_wakeup_queue
   import dispatch_pkg::*;
#(
   parameter  int unsigned DATA_W    = DATA_W_DEF,
   parameter  int unsigned TAG_W     = TAG_W_DEF,
   parameter  int unsigned RD_W      = RD_W_DEF,
   parameter  int unsigned CTRL_W    = CTRL_W_DEF,
   parameter  int unsigned DEPTH     = 8,
   parameter  int unsigned ENQ_LANES = 2,
   parameter  int unsigned CDB_PORTS = 2,
   localparam int unsigned ENTRY_W   = 2*DATA_W + 2 + RD_W + CTRL_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic [ENQ_LANES-1:0]            enq_valid,
   input  logic [ENQ_LANES*ENTRY_W-1:0]    enq_inst,
   output logic                            enq_ready,
   input  logic [CDB_PORTS-1:0]            cdb_valid,
   input  logic [CDB_PORTS*TAG_W-1:0]      cdb_tag,
   input  logic [CDB_PORTS*DATA_W-1:0]     cdb_value,
   output logic                            deq_valid,
   input  logic                            deq_ready,
   output logic [ENTRY_W-1:0]              deq_inst,
   output logic [$clog2(DEPTH+1)-1:0]      count
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH+1);
   localparam int unsigned O_S1V  = off_s1_valid(CTRL_W, RD_W);
   localparam int unsigned O_S1VT = off_s1_vt(CTRL_W, RD_W);
   localparam int unsigned O_S2V  = off_s2_valid(CTRL_W, RD_W, DATA_W);
   localparam int unsigned O_S2VT = off_s2_vt(CTRL_W, RD_W, DATA_W);

   logic [ENTRY_W-1:0] entries_q [DEPTH];
   logic [ENTRY_W-1:0] entries_d [DEPTH];
   logic [ENTRY_W-1:0] slot_woke [DEPTH];
   logic [ENTRY_W-1:0] lane_woke [ENQ_LANES];

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [DEPTH-1:0] occ;
   logic [PTR_W-1:0] rel;
   logic [PTR_W-1:0] slot;
   logic             deq_fire;
   int unsigned      n_acc;

   // Wakeup for every storage slot; result is only kept for occupied slots.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic              s1v, s2v;
      logic [DATA_W-1:0] s1vt, s2vt;

      operand_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS)) u_s1 (
         .valid_i     (entries_q[g][O_S1V]),
         .vt_i        (entries_q[g][O_S1VT +: DATA_W]),
         .cdb_valid_i (cdb_valid),
         .cdb_tag_i   (cdb_tag),
         .cdb_value_i (cdb_value),
         .valid_o     (s1v),
         .vt_o        (s1vt)
      );

      operand_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS)) u_s2 (
         .valid_i     (entries_q[g][O_S2V]),
         .vt_i        (entries_q[g][O_S2VT +: DATA_W]),
         .cdb_valid_i (cdb_valid),
         .cdb_tag_i   (cdb_tag),
         .cdb_value_i (cdb_value),
         .valid_o     (s2v),
         .vt_o        (s2vt)
      );

      assign slot_woke[g] = {s2vt, s2v, s1vt, s1v, entries_q[g][O_S1V-1:0]};
   end

   // Same-cycle bypass: incoming lanes are woken before being written.
   for (genvar l = 0; l < ENQ_LANES; l++) begin : g_lane
      logic [ENTRY_W-1:0] lane;
      logic               s1v, s2v;
      logic [DATA_W-1:0]  s1vt, s2vt;

      assign lane = enq_inst[l*ENTRY_W +: ENTRY_W];

      operand_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS)) u_s1 (
         .valid_i     (lane[O_S1V]),
         .vt_i        (lane[O_S1VT +: DATA_W]),
         .cdb_valid_i (cdb_valid),
         .cdb_tag_i   (cdb_tag),
         .cdb_value_i (cdb_value),
         .valid_o     (s1v),
         .vt_o        (s1vt)
      );

      operand_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS)) u_s2 (
         .valid_i     (lane[O_S2V]),
         .vt_i        (lane[O_S2VT +: DATA_W]),
         .cdb_valid_i (cdb_valid),
         .cdb_tag_i   (cdb_tag),
         .cdb_value_i (cdb_value),
         .valid_o     (s2v),
         .vt_o        (s2vt)
      );

      assign lane_woke[l] = {s2vt, s2v, s1vt, s1v, lane[O_S1V-1:0]};
   end

   // Outputs come from registered state only; no CDB bypass to the head.
   assign deq_inst  = entries_q[head_q];
   assign deq_valid = (count_q != '0) && deq_inst[O_S1V] && deq_inst[O_S2V];
   assign enq_ready = (count_q <= CNT_W'(DEPTH - ENQ_LANES));
   assign count     = count_q;
   assign deq_fire  = deq_valid && deq_ready;

   // Slot occupancy: distance from head is below the occupied count.
   always_comb begin
      rel = '0;
      occ = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         rel    = PTR_W'(i) - head_q;
         occ[i] = (CNT_W'(rel) < count_q);
      end
   end

   // Next-state storage and pointers: wakeup of held entries, compressed lane writes.
   always_comb begin
      slot  = '0;
      n_acc = enq_ready ? popcount(MAX_LANES'(enq_valid), ENQ_LANES) : 0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         entries_d[i] = occ[i] ? slot_woke[i] : entries_q[i];
      end
      for (int unsigned l = 0; l < ENQ_LANES; l++) begin
         if (enq_ready && enq_valid[l]) begin
            slot            = tail_q + PTR_W'(slot_offset(MAX_LANES'(enq_valid), l));
            entries_d[slot] = lane_woke[l];
         end
      end
      tail_d  = tail_q + PTR_W'(n_acc);
      head_d  = head_q + PTR_W'(deq_fire);
      count_d = count_q + CNT_W'(n_acc) - CNT_W'(deq_fire);
   end

   // State register: reset clears storage, flush only empties the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      end
   end

endmodule

// File: tb/tb_dispatch_wakeup_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_dispatch_wakeup_queue;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 6;
   localparam int DEPTH  = 8;
   localparam int LANES  = 2;
   localparam int PORTS  = 2;
   localparam int EW     = 83;

   typedef struct packed {
      logic [31:0] s2_vt;
      logic        s2_valid;
      logic [31:0] s1_vt;
      logic        s1_valid;
      logic [4:0]  rd;
      logic [11:0] ctrl;
   } ent_t;

   logic                   clk = 1'b0;
   logic                   rst, flush;
   logic [LANES-1:0]       enq_valid;
   logic [LANES*EW-1:0]    enq_inst;
   logic                   enq_ready;
   logic [PORTS-1:0]       cdb_valid;
   logic [PORTS*TAG_W-1:0] cdb_tag;
   logic [PORTS*DATA_W-1:0] cdb_value;
   logic                   deq_valid, deq_ready;
   logic [EW-1:0]          deq_inst;
   logic [3:0]             count;

   always #5 clk = ~clk;

   dispatch_wakeup_queue #(
      .DATA_W(32), .TAG_W(6), .RD_W(5), .CTRL_W(12),
      .DEPTH(8), .ENQ_LANES(2), .CDB_PORTS(2)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_ready(enq_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_inst(deq_inst),
      .count(count)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   ent_t mq[$];
   bit   m_zero;
   ent_t h;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic ent_t mk(input logic s1v, input logic [31:0] s1vt, input logic s2v,
                               input logic [31:0] s2vt, input logic [4:0] rd, input logic [11:0] ctrl);
      ent_t e;
      e.s1_valid = s1v; e.s1_vt = s1vt; e.s2_valid = s2v; e.s2_vt = s2vt;
      e.rd = rd; e.ctrl = ctrl;
      return e;
   endfunction

   // Returns {valid, value} after applying the current broadcasts to one operand.
   function automatic logic [32:0] wake_op(input logic v, input logic [31:0] vt);
      if (v) return {1'b1, vt};
      for (int p = 0; p < PORTS; p++) begin
         if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == vt[5:0])
            return {1'b1, cdb_value[p*DATA_W +: DATA_W]};
      end
      return {1'b0, vt};
   endfunction

   function automatic ent_t wake(input ent_t e);
      ent_t r;
      r = e;
      {r.s1_valid, r.s1_vt} = wake_op(e.s1_valid, e.s1_vt);
      {r.s2_valid, r.s2_vt} = wake_op(e.s2_valid, e.s2_vt);
      return r;
   endfunction

   function automatic bit m_ready();
      return (DEPTH - mq.size()) >= LANES;
   endfunction

   function automatic bit m_deq_valid();
      return mq.size() > 0 && mq[0].s1_valid && mq[0].s2_valid;
   endfunction

   // Advance the model with the inputs the DUT is about to sample.
   task automatic model_step();
      bit rdy, dv;
      if (rst) begin
         mq.delete();
         m_zero = 1'b1;
         return;
      end
      if (flush) begin
         mq.delete();
         return;
      end
      rdy = m_ready();
      dv  = m_deq_valid();
      foreach (mq[i]) mq[i] = wake(mq[i]);
      if (dv && deq_ready) void'(mq.pop_front());
      if (rdy) begin
         for (int l = 0; l < LANES; l++) begin
            if (enq_valid[l]) begin
               mq.push_back(wake(ent_t'(enq_inst[l*EW +: EW])));
               m_zero = 1'b0;
            end
         end
      end
   endtask

   task automatic check_outputs();
      check_eq("count", 128'(count), 128'(mq.size()));
      check_eq("enq_ready", 128'(enq_ready), 128'(m_ready()));
      check_eq("deq_valid", 128'(deq_valid), 128'(m_deq_valid()));
      if (mq.size() > 0)
         check_eq("deq_inst", 128'(deq_inst), 128'(mq[0]));
      else if (m_zero)
         check_eq("deq_inst_zero", 128'(deq_inst), 128'(0));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_inputs();
      rst = 1'b0; flush = 1'b0; enq_valid = '0; enq_inst = '0;
      cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
   endtask

   function automatic ent_t rand_ent();
      ent_t e;
      e.s1_valid = 1'($urandom_range(0, 1));
      e.s2_valid = 1'($urandom_range(0, 1));
      e.s1_vt = e.s1_valid ? $urandom : (($urandom & 32'hFFFF_FFC0) | $urandom_range(0, 15));
      e.s2_vt = e.s2_valid ? $urandom : (($urandom & 32'hFFFF_FFC0) | $urandom_range(0, 15));
      e.rd = 5'($urandom);
      e.ctrl = 12'($urandom);
      return e;
   endfunction

   initial begin
      idle_inputs();
      m_zero = 1'b1;
      rst = 1'b1; deq_ready = 1'b1;
      cycle();
      check_eq("reset_count", 128'(count), 128'(0));
      check_eq("reset_deq_inst", 128'(deq_inst), 128'(0));

      // Ready entry released the cycle after enqueue.
      idle_inputs();
      enq_valid = 2'b01;
      enq_inst  = {ent_t'('0), mk(1'b1, 32'd5, 1'b1, 32'd7, 5'd3, 12'h0)};
      cycle();
      h = deq_inst;
      check_eq("t1_s1vt", 128'(h.s1_vt), 128'(5));
      check_eq("t1_rd", 128'(h.rd), 128'(3));
      idle_inputs();
      cycle();
      check_eq("t1_count0", 128'(count), 128'(0));

      // Waiting s1 woken by CDB port1 two cycles after enqueue.
      enq_valid = 2'b01;
      enq_inst  = {ent_t'('0), mk(1'b0, 32'd9, 1'b1, 32'd1, 5'd4, 12'h5)};
      cycle();
      idle_inputs();
      cycle();
      cdb_valid = 2'b10; cdb_tag = {6'd9, 6'd0}; cdb_value = {32'hDEAD_BEEF, 32'h0};
      check_eq("t2_pre_dv", 128'(deq_valid), 128'(0));
      cycle();
      h = deq_inst;
      check_eq("t2_dv", 128'(deq_valid), 128'(1));
      check_eq("t2_s1vt", 128'(h.s1_vt), 128'(32'hDEAD_BEEF));
      idle_inputs();
      cycle();

      // Lane1 only, woken on the way in.
      deq_ready = 1'b0;
      enq_valid = 2'b10;
      enq_inst  = {mk(1'b1, 32'd1, 1'b0, 32'd4, 5'd7, 12'h1), mk(1'b1, 32'd2, 1'b1, 32'd3, 5'd1, 12'h2)};
      cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd4}; cdb_value = {32'h0, 32'hCAFE_0004};
      cycle();
      h = deq_inst;
      check_eq("t3_count", 128'(count), 128'(1));
      check_eq("t3_s2vt", 128'(h.s2_vt), 128'(32'hCAFE_0004));
      check_eq("t3_rd", 128'(h.rd), 128'(7));
      idle_inputs();

      // Fill to DEPTH-1, overflow group ignored, one dequeue reopens.
      for (int k = 0; k < 3; k++) begin
         enq_valid = 2'b11;
         enq_inst  = {mk(1'b1, 32'(k), 1'b1, 32'd0, 5'(k), 12'h3), mk(1'b1, 32'(k+10), 1'b1, 32'd0, 5'(k), 12'h4)};
         cycle();
      end
      check_eq("t4_count7", 128'(count), 128'(7));
      check_eq("t4_full_ready", 128'(enq_ready), 128'(0));
      enq_valid = 2'b11;
      cycle();
      check_eq("t4_ignored", 128'(count), 128'(7));
      idle_inputs();
      deq_ready = 1'b1;
      cycle();
      check_eq("t4_count6", 128'(count), 128'(6));
      check_eq("t4_ready", 128'(enq_ready), 128'(1));
      flush = 1'b1;
      cycle();

      // Two ports match the same tag: port0 value taken.
      idle_inputs();
      deq_ready = 1'b0;
      enq_valid = 2'b01;
      enq_inst  = {ent_t'('0), mk(1'b0, 32'd2, 1'b1, 32'd0, 5'd2, 12'h6)};
      cycle();
      enq_valid = '0;
      cdb_valid = 2'b11; cdb_tag = {6'd2, 6'd2}; cdb_value = {32'h22, 32'h11};
      cycle();
      h = deq_inst;
      check_eq("t5_s1vt", 128'(h.s1_vt), 128'(32'h11));
      idle_inputs();
      flush = 1'b1;
      cycle();

      // Blocked head then flush with a same-cycle enqueue group.
      idle_inputs();
      deq_ready = 1'b1;
      enq_valid = 2'b11;
      enq_inst  = {mk(1'b1, 32'd1, 1'b1, 32'd1, 5'd9, 12'h8), mk(1'b0, 32'd63, 1'b1, 32'd0, 5'd8, 12'h7)};
      cycle();
      check_eq("t6_count2", 128'(count), 128'(2));
      check_eq("t6_blocked", 128'(deq_valid), 128'(0));
      flush = 1'b1;
      cycle();
      check_eq("t6_flush_count", 128'(count), 128'(0));
      check_eq("t6_flush_dv", 128'(deq_valid), 128'(0));
      idle_inputs();
      cycle();
      check_eq("t6_after_count", 128'(count), 128'(0));

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 299) == 0);
         flush     = ($urandom_range(0, 49) == 0);
         enq_valid = 2'($urandom);
         enq_inst  = {rand_ent(), rand_ent()};
         cdb_valid = 2'($urandom);
         cdb_tag   = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
         cdb_value = {$urandom, $urandom};
         deq_ready = ($urandom_range(0, 4) != 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dispatch_wakeup_queue.md
Name: dispatch_wakeup_queue

Overview:
- Parametrised in-order dispatch queue between instruction decompose and the execute/issue stage.
- Accepts up to ENQ_LANES decomposed instructions per cycle in the standard packed entry format {s2_vt, s2_valid, s1_vt, s1_valid, rd, ctrl_signal}.
- Holds the entries while waiting operand tags are woken up by CDB broadcasts, capturing the broadcast value.
- Releases the head entry once both operands are valid and downstream is ready.

Parameters:
DATA_W, 32, operand value/tag field width
TAG_W, 6, tag bits; compared against vt[TAG_W-1:0] when valid=0
RD_W, 5, destination register field width
CTRL_W, 12, control signal field width
DEPTH, 8, entries; power of two, >= ENQ_LANES
ENQ_LANES, 2, enqueue lanes per cycle
CDB_PORTS, 2, result broadcast ports
ENTRY_W, 2*DATA_W+2+RD_W+CTRL_W (=83), derived; not overridable

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous queue clear (mispredict)
enq_valid  in  ENQ_LANES  per-lane instruction valid
enq_inst  in  ENQ_LANES*ENTRY_W  lane i at [i*ENTRY_W +: ENTRY_W]
enq_ready  out  1  queue accepts a full enqueue group this cycle
cdb_valid  in  CDB_PORTS  broadcast valid
cdb_tag  in  CDB_PORTS*TAG_W  broadcast tags
cdb_value  in  CDB_PORTS*DATA_W  broadcast results
deq_valid  out  1  head entry present with both operands valid
deq_ready  in  1  downstream accepts head
deq_inst  out  ENTRY_W  head entry; valid bits and values after wakeup
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset: rst=1 at a clock edge sets head, tail and count to 0 and clears all entry storage to 0.
  - Outputs after reset: enq_ready=1, deq_valid=0, deq_inst=0, count=0.
  - rst overrides every other input, including mid-operation.
- Priority: rst > flush > enqueue/dequeue/wakeup.
  - flush empties the queue at the edge; all same-cycle enq and deq are dropped.
- enq_ready = (DEPTH - count) >= ENQ_LANES, computed from registered count only.
  - A same-cycle dequeue does not raise enq_ready.
- Enqueue, when enq_ready=1:
  - Lanes with enq_valid=1 are written in ascending lane order to consecutive slots starting at tail. Gaps between valid lanes are compressed.
  - tail advances by popcount(enq_valid) modulo DEPTH.
  - enq_valid with enq_ready=0 is ignored; the source holds the group.
- Wakeup applies every cycle to all occupied entries and to incoming lanes (same-cycle bypass).
  - For each operand with valid=0, if cdb_valid[p]=1 and cdb_tag[p]==vt[TAG_W-1:0], set valid=1 and vt=cdb_value[p].
  - If several ports match, the lowest index p wins.
  - Operands already valid are never modified.
- Dequeue:
  - deq_valid = count!=0 && head s1_valid && s2_valid, from registered state only. No same-cycle CDB bypass to the output.
  - deq_inst always shows the head entry, even when deq_valid=0.
  - Transfer occurs when deq_valid && deq_ready; head advances by 1 modulo DEPTH.
  - In-order only: a blocked head stalls younger ready entries.
- Latency:
  - Entry enqueued at edge N with valid operands can assert deq_valid from cycle N+1.
  - A CDB match at edge N asserts deq_valid from cycle N+1.
- Simultaneous enqueue and dequeue: count_next = count + popcount(accepted lanes) - deq_fire.
- Pointers are $clog2(DEPTH) bits and wrap naturally; count distinguishes full from empty.
- count never exceeds DEPTH; enqueue into a full queue is impossible by construction of enq_ready.

Decomposition:
- Package dispatch_pkg holds:
  - localparam field offsets for ctrl, rd, s1_valid, s1_vt, s2_valid, s2_vt within ENTRY_W;
  - a function popcount for ENQ_LANES;
  - a function compressing lane index to slot offset.
- Sub-module operand_wakeup: combinational; inputs valid, vt, cdb_valid/cdb_tag/cdb_value buses; outputs new valid and new vt.
  - Instantiated 2*(DEPTH+ENQ_LANES) times.

Test Plan:
- Reset, then enqueue lane0 {s1_valid=1, s1_vt=5, s2_valid=1, s2_vt=7, rd=3} with deq_ready=1 -> deq_valid=1 on the next cycle with the same fields; count goes 1 then 0.
- Enqueue entry with s1_valid=0, tag 9; CDB port1 broadcasts tag 9 value 0xDEADBEEF two cycles later -> deq_valid rises the cycle after the broadcast; deq_inst s1_vt=0xDEADBEEF, s1_valid=1.
- enq_valid=2'b10 with the CDB matching lane1's s2 tag 4 in the same cycle -> entry stored at tail with s2_valid=1 and the broadcast value; tail advances by 1.
- Fill to DEPTH-1 (count=7) -> enq_ready=0; a 2-lane group is ignored; after one dequeue, count=6 and enq_ready=1.
- Both CDB ports broadcast tag 2 with values 0x11 and 0x22 -> the waiting operand captures 0x11.
- Head blocked while entry 2 is ready; assert flush with enq_valid=2'b11 -> count=0, deq_valid=0, and no lanes written next cycle.
